// File: rtl/buffer_write_arbiter_pkg.sv
// Shared definitions for the buffer write arbiter: source index sizing and
// the round-robin pointer reset value.
package buffer_write_arbiter_pkg;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int POINTER_RESET = 0;

endpackage

// File: rtl/buffer_write_arbiter_round_robin_arbiter.sv
// Round-robin arbiter: combinational search from the pointer, ascending with
// wrap, one-hot grant qualified by enable. Owns the pointer register.
module round_robin_arbiter
    import buffer_write_arbiter_pkg::*;
#(
    parameter  int REQUESTERS = 4,
    localparam int IW         = index_width(REQUESTERS)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [REQUESTERS-1:0] request,
    input  logic                  enable,
    output logic [REQUESTERS-1:0] grant,
    output logic [IW-1:0]         winner
);

    logic [IW-1:0] pointer;
    logic          found;
    int            idx;

    // First requesting source at or after the pointer, wrapping at the top.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(pointer) + k) % REQUESTERS;
            if (!found && request[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Only the winner's bit can rise, and only when the slot can take data.
    always_comb begin
        grant = '0;
        if (enable && found)
            grant[winner] = 1'b1;
    end

    generate
        if (REQUESTERS == 1) begin : g_single
            assign pointer = IW'(POINTER_RESET);
        end else begin : g_multi
            // Advance past the winner on every accepted write; hold otherwise.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn)
                    pointer <= IW'(POINTER_RESET);
                else if (|grant)
                    pointer <= (winner == IW'(REQUESTERS - 1)) ? '0 : winner + 1'b1;
            end
        end
    endgenerate

endmodule

// File: rtl/buffer_write_arbiter.sv
// Single-entry buffer shared by REQUESTERS producers via round-robin
// arbitration. Stores the winner's data and source index; consumer pops with
// read_enable. Define BUFFER_WRITE_ARBITER_PASSTHROUGH_EN to allow a new write
// in the same cycle the consumer pops a full slot (one transfer per cycle).
module buffer_write_arbiter
    import buffer_write_arbiter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REQUESTERS  = 4,
    parameter int INDEX_WIDTH = index_width(REQUESTERS)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [REQUESTERS-1:0]       request,
    input  logic [REQUESTERS*WIDTH-1:0] request_data,
    output logic [REQUESTERS-1:0]       grant,
    input  logic                        read_enable,
    output logic [WIDTH-1:0]            read_data,
    output logic [INDEX_WIDTH-1:0]      read_source,
    output logic                        full,
    output logic                        empty
);

    logic                   valid;
    logic                   write_allowed;
    logic                   accept;
    logic [INDEX_WIDTH-1:0] winner;
    logic [WIDTH-1:0]       winner_data;

    // resetn gates the enable so nothing is granted while reset is held.
`ifdef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
    assign write_allowed = resetn & (~valid | read_enable);
`else
    assign write_allowed = resetn & ~valid;
`endif

    round_robin_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_arb (
        .clock   (clock),
        .resetn  (resetn),
        .request (request),
        .enable  (write_allowed),
        .grant   (grant),
        .winner  (winner)
    );

    assign accept      = |grant;
    assign winner_data = request_data[int'(winner)*WIDTH +: WIDTH];

    // Write wins over a simultaneous pop; a pop of an empty slot is ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_data   <= '0;
            read_source <= '0;
            valid       <= 1'b0;
        end else if (accept) begin
            read_data   <= winner_data;
            read_source <= winner;
            valid       <= 1'b1;
        end else if (read_enable && valid) begin
            valid       <= 1'b0;
        end
    end

    assign full  = valid;
    assign empty = ~valid;

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter (WIDTH=8, REQUESTERS=4).
module tb_buffer_write_arbiter;

    logic        clock;
    logic        resetn;
    logic [3:0]  request;
    logic [31:0] request_data;
    logic [3:0]  grant;
    logic        read_enable;
    logic [7:0]  read_data;
    logic [1:0]  read_source;
    logic        full;
    logic        empty;

    int tests = 0;
    int fails = 0;

    buffer_write_arbiter #(.WIDTH(8), .REQUESTERS(4)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .request      (request),
        .request_data (request_data),
        .grant        (grant),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_source  (read_source),
        .full         (full),
        .empty        (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        request = 4'b0000; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; request = 4'b1111; read_enable = 1'b0;
        request_data = {8'h13, 8'h12, 8'h11, 8'h10};
        #3;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got %b want 0000", grant); end
        repeat (2) @(posedge clock);
        request = 4'b0000;
        @(negedge clock);
        resetn = 1'b1;
        tick();
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL idle_grant got %b want 0000", grant); end
        tests++; if (read_source !== 2'd0) begin fails++; $display("FAIL reset_src got %0d want 0", read_source); end
        tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", read_data); end
    endtask

    // Grants 0,1,2,3,0 with each write drained before the next.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        for (int k = 0; k < 5; k++) begin
            request = 4'b1111; read_enable = 1'b0;
            #1;
            exp_g = 4'b0001 << (k % 4);
            tests++; if (grant !== exp_g) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", k, grant, exp_g); end
            tick();
            tests++; if (full !== 1'b1 || read_source !== 2'(k % 4) || read_data !== 8'(8'h10 + k % 4)) begin
                fails++; $display("FAIL rr_read[%0d] got full=%b src=%0d data=%h want full=1 src=%0d data=%h",
                                  k, full, read_source, read_data, k % 4, 8'h10 + k % 4);
            end
            read_enable = 1'b1;
`ifdef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
            request = 4'b0000;
`else
            #1;
            tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL rr_full_grant[%0d] got %b want 0000", k, grant); end
`endif
            tick();
        end
        read_enable = 1'b0; request = 4'b0000;
    endtask

`ifndef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
    // Pointer is 1 on entry; fill with requester 0, then hold off requester 2.
    task automatic test_backpressure();
        request = 4'b0001; #1;
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL bp_fill got %b want 0001", grant); end
        tick();
        request = 4'b0100; #1;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL bp_hold_grant got %b want 0000", grant); end
        tick();
        tests++; if (full !== 1'b1 || read_data !== 8'h10) begin fails++; $display("FAIL bp_hold_data got full=%b data=%h want full=1 data=10", full, read_data); end
        read_enable = 1'b1; #1;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL bp_pop_grant got %b want 0000", grant); end
        tick();
        read_enable = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL bp_empty got %b want 1", empty); end
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL bp_grant2 got %b want 0100", grant); end
        tick();
        tests++; if (read_data !== 8'h12 || read_source !== 2'd2) begin fails++; $display("FAIL bp_read got data=%h src=%0d want 12/2", read_data, read_source); end
        drain();
    endtask
`endif

    task automatic test_wrap();
        request = 4'b0100; #1;
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL wrap_setup got %b want 0100", grant); end
        tick();
        drain();
        request = 4'b1001; #1;
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL wrap_g3 got %b want 1000", grant); end
        tick();
        tests++; if (read_source !== 2'd3 || read_data !== 8'h13) begin fails++; $display("FAIL wrap_r3 got src=%0d data=%h want 3/13", read_source, read_data); end
        drain();
        request = 4'b1001; #1;
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL wrap_g0 got %b want 0001", grant); end
        tick();
        tests++; if (read_source !== 2'd0 || read_data !== 8'h10) begin fails++; $display("FAIL wrap_r0 got src=%0d data=%h want 0/10", read_source, read_data); end
        drain();
    endtask

    task automatic test_spurious_read();
        request = 4'b0000; read_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (full !== 1'b0) begin fails++; $display("FAIL spur_full[%0d] got %b want 0", k, full); end
            tick();
        end
        tests++; if (full !== 1'b0 || read_data !== 8'h10) begin fails++; $display("FAIL spur_state got full=%b data=%h want 0/10", full, read_data); end
        read_enable = 1'b0; request = 4'b0010; #1;
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL spur_grant got %b want 0010", grant); end
        tick();
        tests++; if (full !== 1'b1 || read_source !== 2'd1 || read_data !== 8'h11) begin fails++; $display("FAIL spur_read got full=%b src=%0d data=%h want 1/1/11", full, read_source, read_data); end
        drain();
    endtask

`ifdef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
    // Pointer is 2 on entry.
    task automatic test_passthrough();
        logic [3:0] exp_g;
        int         w;
        request = 4'b0010; #1;
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL pt_fill got %b want 0010", grant); end
        tick();
        request_data[15:8] = 8'h21; read_enable = 1'b1; #1;
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL pt_same_cycle got %b want 0010", grant); end
        tick();
        tests++; if (full !== 1'b1 || read_data !== 8'h21 || read_source !== 2'd1) begin fails++; $display("FAIL pt_read got full=%b data=%h src=%0d want 1/21/1", full, read_data, read_source); end
        request_data[15:8] = 8'h11;
        for (int j = 0; j < 8; j++) begin
            request = 4'b1111; read_enable = 1'b1; #1;
            w = (2 + j) % 4;
            exp_g = 4'b0001 << w;
            tests++; if (grant !== exp_g) begin fails++; $display("FAIL pt_grant[%0d] got %b want %b", j, grant, exp_g); end
            tick();
            tests++; if (full !== 1'b1 || read_source !== 2'(w) || read_data !== 8'(8'h10 + w)) begin
                fails++; $display("FAIL pt_stream[%0d] got full=%b src=%0d data=%h want 1/%0d/%h", j, full, read_source, read_data, w, 8'h10 + w);
            end
        end
        drain();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pt_drain got %b want 1", empty); end
    endtask
`endif

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout bench did not finish");
                $fatal(1);
            end
        join_none
        test_reset();
        test_round_robin();
`ifndef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
        test_backpressure();
`endif
        test_wrap();
        test_spurious_read();
`ifdef BUFFER_WRITE_ARBITER_PASSTHROUGH_EN
        test_passthrough();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
